// File: rtl/fpq_pkg.sv
// Shared constants, FSM encoding and length helper for the packet FIFO / server pair.
package fpq_pkg;

    localparam int PKT_LEN_W  = 8;
    localparam int BYTE_CNT_W = 12;
    localparam int MTU_UNITS  = 95;
    localparam int MIN_UNITS  = 4;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_SERVE   = 2'd1,
        ST_DRAINED = 2'd2
    } fsm_state_t;

    // Remaining head length in 16-byte units, rounded up.
    function automatic logic [PKT_LEN_W-1:0] bytes_to_units(input logic [BYTE_CNT_W-1:0] b);
        return b[BYTE_CNT_W-1:4] + {{(PKT_LEN_W-1){1'b0}}, (b[3:0] != 4'd0)};
    endfunction

endpackage

// File: rtl/q_pkt_fifo_mem.sv
// Packet-length storage: one synchronous write port, one asynchronous read port.
module q_pkt_fifo_mem
    import fpq_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = PKT_LEN_W
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem_reg [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/q_pkt_fifo.sv
// Packet-length FIFO feeding a byte-per-clock server; head is popped on the go falling edge.
// Optional drop statistics enabled by defining Q_PKT_FIFO_DROP_STATS_EN.
module q_pkt_fifo
    import fpq_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int PKT_LEN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [PKT_LEN_W-1:0]  push_len,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    input  logic                  go,
    output logic [PKT_LEN_W-1:0]  pkt_len,
    output logic                  bool_new_pkt,
    output logic [7:0]            drop_cnt
);

    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    fsm_state_t            state_reg, state_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, wr_ptr_reg, raddr;
    logic [CNT_W-1:0]      count_reg;
    logic [BYTE_CNT_W-1:0] byte_cnt_reg, byte_cnt_next;
    logic                  go_d_reg, new_pkt_reg;
    logic                  load_head, pop, dec, accept, go_fall, more_left;
    logic [PKT_LEN_W-1:0]  head_len;

    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign go_fall   = go_d_reg & ~go;
    assign more_left = (count_reg > CNT_W'(1));
    // A pop in the same edge frees the slot, so a push into a full FIFO still lands.
    assign accept    = push && (push_len != '0) && (!full || pop);

    q_pkt_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (PKT_LEN_W)
    ) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr_reg),
        .wdata (push_len),
        .raddr (raddr),
        .rdata (head_len)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY:   if (!empty) state_next = ST_SERVE;
            ST_SERVE:   if (go && byte_cnt_reg == BYTE_CNT_W'(1)) state_next = ST_DRAINED;
            ST_DRAINED: if (go_fall) state_next = more_left ? ST_SERVE : ST_EMPTY;
            default:    state_next = ST_EMPTY;
        endcase
    end

    // On a pop the following head is read one slot ahead so it loads in the same edge.
    always_comb begin
        load_head = 1'b0;
        pop       = 1'b0;
        dec       = 1'b0;
        raddr     = rd_ptr_reg;
        case (state_reg)
            ST_EMPTY:   load_head = !empty;
            ST_SERVE:   dec = go;
            ST_DRAINED: begin
                if (go_fall) begin
                    pop       = 1'b1;
                    load_head = more_left;
                    raddr     = rd_ptr_reg + DEPTH_LOG2'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_cnt_next = byte_cnt_reg;
        if (load_head) begin
            byte_cnt_next = BYTE_CNT_W'({head_len, 4'b0000});
        end else if (dec) begin
            byte_cnt_next = byte_cnt_reg - BYTE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            byte_cnt_reg <= '0;
            go_d_reg     <= 1'b0;
            new_pkt_reg  <= 1'b0;
        end else begin
            go_d_reg     <= go;
            new_pkt_reg  <= load_head;
            byte_cnt_reg <= byte_cnt_next;
            count_reg    <= count_reg + CNT_W'(accept) - CNT_W'(pop);
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
            end
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
            end
        end
    end

`ifdef Q_PKT_FIFO_DROP_STATS_EN
    logic       reject;
    logic [7:0] drop_cnt_reg;

    assign reject = push && (push_len != '0) && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
        end else if (reject && drop_cnt_reg != 8'hFF) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`else
    assign drop_cnt = '0;
`endif

    assign count        = count_reg;
    assign pkt_len      = PKT_LEN_W'(bytes_to_units(byte_cnt_reg));
    assign bool_new_pkt = new_pkt_reg;

endmodule

// File: tb/tb_q_pkt_fifo.sv
// Directed bench for q_pkt_fifo: queue-level reference model checked every cycle plus literal checkpoints.
module tb_q_pkt_fifo;

    localparam int DEPTH = 16;
`ifdef Q_PKT_FIFO_DROP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push = 1'b0;
    logic       go = 1'b0;
    logic [7:0] push_len = 8'd0;
    logic       full, empty, bool_new_pkt;
    logic [4:0] count;
    logic [7:0] pkt_len, drop_cnt;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: list of stored lengths (head first) and bytes left on the head.
    int m_q[$];
    int m_rem = 0;
    bit m_head = 1'b0;
    bit m_new = 1'b0;
    int m_drop = 0;
    bit m_prev_go = 1'b0;

    q_pkt_fifo #(
        .DEPTH_LOG2 (4),
        .PKT_LEN_W  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .push_len     (push_len),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .go           (go),
        .pkt_len      (pkt_len),
        .bool_new_pkt (bool_new_pkt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    task automatic model_step();
        int n_old;
        bit do_pop;
        if (!rst_n) begin
            m_q.delete();
            m_rem = 0;
            m_head = 1'b0;
            m_new = 1'b0;
            m_drop = 0;
            m_prev_go = 1'b0;
            return;
        end
        n_old  = m_q.size();
        do_pop = m_head && (m_rem == 0) && m_prev_go && !go;
        m_new  = 1'b0;
        if (m_head && m_rem > 0 && go) m_rem--;
        if (do_pop) begin
            void'(m_q.pop_front());
            if (m_q.size() > 0) begin
                m_rem = m_q[0] * 16;
                m_new = 1'b1;
            end else begin
                m_head = 1'b0;
            end
        end else if (!m_head && n_old > 0) begin
            m_head = 1'b1;
            m_rem = m_q[0] * 16;
            m_new = 1'b1;
        end
        if (push && push_len != 8'd0) begin
            if (n_old < DEPTH || do_pop) m_q.push_back(int'(push_len));
            else if (STATS && m_drop < 255) m_drop++;
        end
        m_prev_go = go;
    endtask

    task automatic cyc(input bit p, input int l, input bit g);
        push = p;
        push_len = 8'(l);
        go = g;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic serve(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", int'(count), m_q.size());
            chk("full", int'(full), int'(m_q.size() == DEPTH));
            chk("empty", int'(empty), int'(m_q.size() == 0));
            chk("pkt_len", int'(pkt_len), (m_rem + 15) / 16);
            chk("bool_new_pkt", int'(bool_new_pkt), int'(m_new));
            chk("drop_cnt", int'(drop_cnt), m_drop);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int lens[3];
        int sat;

        // Reset
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_pkt_len", int'(pkt_len), 0);
        chk("rst_new", int'(bool_new_pkt), 0);
        chk("rst_drop", int'(drop_cnt), 0);

        // Single 4-unit packet served with go held high
        cyc(1'b1, 4, 1'b1);
        chk("s1_count", int'(count), 1);
        cyc(1'b0, 0, 1'b1);
        chk("s1_new", int'(bool_new_pkt), 1);
        chk("s1_len", int'(pkt_len), 4);
        pulses = 0;
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, 0, 1'b1);
            pulses += int'(bool_new_pkt);
            if (i == 15) chk("s1_len_16", int'(pkt_len), 3);
        end
        chk("s1_pulses", pulses, 0);
        chk("s1_len_end", int'(pkt_len), 0);
        chk("s1_count_end", int'(count), 1);
        cyc(1'b0, 0, 1'b0);
        chk("s1_pop_count", int'(count), 0);
        chk("s1_pop_empty", int'(empty), 1);

        // Three packets, each served fully then released by go falling
        lens[0] = 8; lens[1] = 16; lens[2] = 32;
        cyc(1'b1, 8, 1'b0);
        cyc(1'b1, 16, 1'b0);
        chk("s2_new", int'(bool_new_pkt), 1);
        chk("s2_len0", int'(pkt_len), 8);
        cyc(1'b1, 32, 1'b0);
        chk("s2_count", int'(count), 3);
        for (int k = 0; k < 3; k++) begin
            serve(lens[k] * 16);
            cyc(1'b0, 0, 1'b0);
            chk("s2_count_pop", int'(count), 2 - k);
            if (k < 2) begin
                chk("s2_new_head", int'(bool_new_pkt), 1);
                chk("s2_head_len", int'(pkt_len), lens[k + 1]);
            end else begin
                chk("s2_empty", int'(empty), 1);
            end
        end

        // Fill to full, overflow, drop saturation
        for (int i = 1; i <= 16; i++) cyc(1'b1, i, 1'b0);
        chk("s3_full", int'(full), 1);
        chk("s3_count", int'(count), 16);
        cyc(1'b1, 17, 1'b0);
        chk("s3_count_ovf", int'(count), 16);
        chk("s3_drop1", int'(drop_cnt), STATS ? 1 : 0);
        for (int i = 0; i < 260; i++) cyc(1'b1, 9, 1'b0);
        sat = STATS ? 255 : 0;
        chk("s3_drop_sat", int'(drop_cnt), sat);

        // Push onto a full FIFO on the same edge as the pop
        serve(16);
        chk("s4_drained_len", int'(pkt_len), 0);
        cyc(1'b1, 6, 1'b0);
        chk("s4_count", int'(count), 16);
        chk("s4_drop", int'(drop_cnt), sat);
        chk("s4_new", int'(bool_new_pkt), 1);
        chk("s4_len", int'(pkt_len), 2);
        for (int h = 2; h <= 16; h++) begin
            serve(h * 16);
            cyc(1'b0, 0, 1'b0);
            chk("s4_drain_count", int'(count), 17 - h);
            chk("s4_drain_len", int'(pkt_len), (h < 16) ? h + 1 : 6);
        end
        serve(96);
        cyc(1'b0, 0, 1'b0);
        chk("s4_empty", int'(empty), 1);

        // Zero-length push ignored; go while empty does nothing
        cyc(1'b1, 0, 1'b1);
        chk("s5_count", int'(count), 0);
        chk("s5_len", int'(pkt_len), 0);
        chk("s5_drop", int'(drop_cnt), sat);

        // Push on the pop edge of the last entry: reload from EMPTY next edge
        cyc(1'b1, 1, 1'b0);
        cyc(1'b0, 0, 1'b0);
        chk("s6_len1", int'(pkt_len), 1);
        serve(16);
        cyc(1'b1, 3, 1'b0);
        chk("s6_count", int'(count), 1);
        chk("s6_new0", int'(bool_new_pkt), 0);
        chk("s6_len0", int'(pkt_len), 0);
        cyc(1'b0, 0, 1'b0);
        chk("s6_new1", int'(bool_new_pkt), 1);
        chk("s6_len3", int'(pkt_len), 3);
        serve(48);
        cyc(1'b0, 0, 1'b0);
        chk("s6_empty", int'(empty), 1);

        // MTU packet preempted after 100 bytes, then resumed
        cyc(1'b1, 95, 1'b0);
        cyc(1'b0, 0, 1'b0);
        chk("s7_len95", int'(pkt_len), 95);
        serve(100);
        cyc(1'b0, 0, 1'b0);
        chk("s7_len89", int'(pkt_len), 89);
        chk("s7_count", int'(count), 1);
        serve(1419);
        chk("s7_len1", int'(pkt_len), 1);
        serve(1);
        chk("s7_len0", int'(pkt_len), 0);
        chk("s7_count_end", int'(count), 1);
        cyc(1'b0, 0, 1'b0);
        chk("s7_empty", int'(empty), 1);

        // Reset in the middle of serving with 5 entries
        for (int i = 0; i < 5; i++) cyc(1'b1, 3, 1'b0);
        serve(10);
        chk("s8_count", int'(count), 5);
        chk("s8_len", int'(pkt_len), 3);
        rst_n = 1'b0;
        cyc(1'b0, 0, 1'b1);
        rst_n = 1'b1;
        chk("s8_rst_len", int'(pkt_len), 0);
        chk("s8_rst_empty", int'(empty), 1);
        chk("s8_rst_count", int'(count), 0);
        chk("s8_rst_drop", int'(drop_cnt), 0);
        cyc(1'b1, 2, 1'b0);
        chk("s8_count1", int'(count), 1);
        chk("s8_len_pre", int'(pkt_len), 0);
        cyc(1'b0, 0, 1'b0);
        chk("s8_len2", int'(pkt_len), 2);
        chk("s8_new", int'(bool_new_pkt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
